// File: rtl/uart_sched_pkg.sv
// Shared definitions for the uart_tx round-robin scheduler.
// FSM state codes, requester-count limits, byte width and the pointer-advance helper.
package uart_sched_pkg;

    localparam int BYTE_W    = 8;
    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 8;
    localparam int IDX_W     = 3;   // enough to index N_REQ_MAX requesters

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_START = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    // Circular successor of index g among n requesters.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g, input int n);
        if (int'(g) >= n - 1)
            return '0;
        return g + IDX_W'(1);
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational circular-priority select: the first asserted request at or
// after the pointer wins. Produces a one-hot grant plus its index.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from farthest to nearest so the requester closest to the pointer is the final write.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(i_ptr) + k) % N;
            if (i_req[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serializer among N_REQ byte sources.
// One byte in flight at a time: IDLE (grant) -> LOAD -> START -> WAIT (done edge).
// Optional packet lock: define UART_SCHED_LOCK_EN to keep the grant on one
// requester until it sends a byte flagged req_last.
// N_REQ must lie in 2..8 (grant_id is 3 bits wide).
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    cfg_en,
    input  logic [15:0]             cfg_baud_div,
    output logic                    tx_en,
    output logic                    tx_start,
    output logic [BYTE_W-1:0]       tx_data,
    output logic [15:0]             tx_baud_div,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [IDX_W-1:0]        grant_id,
    output logic [CNT_W-1:0]        sent_cnt
);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_gid;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tx_en;
    logic [BYTE_W-1:0] r_tx_data;
    logic [15:0]       r_baud;
    logic              r_done_d;

    logic [N_REQ-1:0]  w_req;
    logic [N_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic [BYTE_W-1:0] w_byte;
    logic              w_done_rise;

`ifdef UART_SCHED_LOCK_EN
    logic r_last;   // req_last of the byte in flight
    logic r_lock;   // packet open: only r_ptr may be granted

    // While a packet is open, hide every requester except the locked one.
    always_comb begin
        w_req = req_valid;
        if (r_lock)
            w_req = req_valid & (N_REQ'(1) << r_ptr);
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^req_last;

    // Pure byte-level round robin: every valid requester competes.
    always_comb begin
        w_req = req_valid;
    end
`endif

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Select the granted requester's byte through the one-hot grant.
    always_comb begin
        w_byte = '0;
        for (int i = 0; i < N_REQ; i++)
            if (w_gnt[i])
                w_byte = req_data[BYTE_W*i +: BYTE_W];
    end

    // A frame ends only on a fresh rising edge; a level left high from an older frame does not count.
    assign w_done_rise = tx_done & ~r_done_d;

    // Accept pulse only in IDLE with the scheduler enabled; byte is taken on this same cycle.
    assign req_ready   = (r_state == ST_IDLE && cfg_en && !rst) ? w_gnt : '0;
    assign tx_start    = (r_state == ST_START);
    assign busy        = (r_state != ST_IDLE);
    assign tx_en       = r_tx_en;
    assign tx_data     = r_tx_data;
    assign tx_baud_div = r_baud;
    assign grant_id    = r_gid;
    assign sent_cnt    = r_cnt;

    // Scheduler FSM, pointer, byte counter and done-edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_gid     <= '0;
            r_cnt     <= '0;
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
            r_baud    <= '0;
            r_done_d  <= 1'b0;
`ifdef UART_SCHED_LOCK_EN
            r_last    <= 1'b0;
            r_lock    <= 1'b0;
`endif
        end else begin
            r_done_d <= tx_done;
            case (r_state)
                ST_IDLE: begin
                    // Enable and divisor are only sampled between frames.
                    r_tx_en <= cfg_en;
                    r_baud  <= cfg_baud_div;
                    if (cfg_en && w_any) begin
                        r_tx_data <= w_byte;
                        r_gid     <= w_idx;
                        r_state   <= ST_LOAD;
`ifdef UART_SCHED_LOCK_EN
                        r_last    <= |(req_last & w_gnt);
`endif
                    end
                end
                ST_LOAD:  r_state <= ST_START;
                ST_START: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_done_rise) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= ST_IDLE;
`ifdef UART_SCHED_LOCK_EN
                        if (!r_last) begin
                            r_ptr  <= r_gid;
                            r_lock <= 1'b1;
                        end else begin
                            r_ptr  <= next_idx(r_gid, N_REQ);
                            r_lock <= 1'b0;
                        end
`else
                        r_ptr   <= next_idx(r_gid, N_REQ);
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (N_REQ=4). The serializer's done output is
// driven by the bench itself; expected values are hand-derived per step.
module tb_uart_tx_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        cfg_en;
    logic [15:0] cfg_baud_div;
    logic        tx_en;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] tx_baud_div;
    logic        tx_done;
    logic        busy;
    logic [2:0]  grant_id;
    logic [15:0] sent_cnt;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    uart_tx_sched #(.N_REQ(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .cfg_en       (cfg_en),
        .cfg_baud_div (cfg_baud_div),
        .tx_en        (tx_en),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_baud_div  (tx_baud_div),
        .tx_done      (tx_done),
        .busy         (busy),
        .grant_id     (grant_id),
        .sent_cnt     (sent_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point sits 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        tx_done = 1'b0;
        step();
        step();
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    // One complete frame starting from IDLE: grant g carrying byte d.
    task automatic frame(input int g, input logic [7:0] d, input logic [3:0] v_after, input int wait_cyc);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        #1;
        check("accept_ready", 32'(req_ready), 32'(oh));
        check("accept_nostart", 32'(tx_start), 32'd0);
        step();
        req_valid = v_after;
        check("load_gid", 32'(grant_id), 32'(g));
        check("load_data", 32'(tx_data), 32'(d));
        check("load_nostart", 32'(tx_start), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        check("load_noready", 32'(req_ready), 32'd0);
        step();
        check("start_pulse", 32'(tx_start), 32'd1);
        step();
        check("wait_nostart", 32'(tx_start), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        repeat (wait_cyc) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        exp_cnt++;
        check("done_cnt", 32'(sent_cnt), 32'(exp_cnt));
        check("done_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        cfg_en       = 1'b0;
        cfg_baud_div = 16'd9;
        tx_done      = 1'b0;

        // Reset values while rst is held
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_baud", 32'(tx_baud_div), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_cnt", 32'(sent_cnt), 32'd0);
        rst = 1'b0;

        // 1: single byte from requester 0
        cfg_en    = 1'b1;
        req_data  = 32'h000000A5;
        req_valid = 4'b0001;
        frame(0, 8'hA5, 4'b0000, 3);
        check("t1_tx_en", 32'(tx_en), 32'd1);
        check("t1_baud", 32'(tx_baud_div), 32'd9);

        // 2: fairness with all four valid
        do_reset();
        req_data  = 32'h43322110;
        req_valid = 4'b1111;
        frame(0, 8'h10, 4'b1111, 1);
        frame(1, 8'h21, 4'b1111, 0);
        frame(2, 8'h32, 4'b1111, 2);
        frame(3, 8'h43, 4'b1111, 0);
        frame(0, 8'h10, 4'b0000, 0);
        check("t2_cnt5", 32'(sent_cnt), 32'd5);

        // 3: cfg changes during WAIT
        do_reset();
        req_valid = 4'b0100;
        #1;
        check("t3_ready", 32'(req_ready), 32'b0100);
        step();
        check("t3_gid", 32'(grant_id), 32'd2);
        check("t3_data", 32'(tx_data), 32'h32);
        step();
        step();
        cfg_baud_div = 16'd4;
        cfg_en       = 1'b0;
        step();
        check("t3_baud_held", 32'(tx_baud_div), 32'd9);
        check("t3_en_held", 32'(tx_en), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("t3_cnt", 32'(sent_cnt), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_no_grant", 32'(req_ready), 32'd0);
        check("t3_en_still", 32'(tx_en), 32'd1);
        step();
        check("t3_en_drop", 32'(tx_en), 32'd0);
        check("t3_baud_new", 32'(tx_baud_div), 32'd4);
        check("t3_no_grant2", 32'(req_ready), 32'd0);
        check("t3_idle2", 32'(busy), 32'd0);
        req_valid    = 4'b0000;
        cfg_baud_div = 16'd9;
        cfg_en       = 1'b1;

        // 4: reset asserted in WAIT
        do_reset();
        req_valid = 4'b0001;
        frame(0, 8'h10, 4'b0011, 0);
        #1;
        check("t4_ready1", 32'(req_ready), 32'b0010);
        step();
        check("t4_gid1", 32'(grant_id), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_tx_en", 32'(tx_en), 32'd0);
        check("t4_start", 32'(tx_start), 32'd0);
        check("t4_data", 32'(tx_data), 32'd0);
        check("t4_baud", 32'(tx_baud_div), 32'd0);
        check("t4_gid", 32'(grant_id), 32'd0);
        check("t4_cnt", 32'(sent_cnt), 32'd0);
        check("t4_ready", 32'(req_ready), 32'd0);
        rst     = 1'b0;
        exp_cnt = 0;
        frame(0, 8'h10, 4'b0000, 0);

        // 5: packet lock vs byte-level round robin
        do_reset();
        req_last  = 4'b0001;
        req_valid = 4'b0001;
        frame(0, 8'h10, 4'b0011, 0);
`ifdef UART_SCHED_LOCK_EN
        frame(1, 8'h21, 4'b0011, 0);
        frame(1, 8'h21, 4'b0011, 0);
        req_last = 4'b0011;
        frame(1, 8'h21, 4'b0011, 0);
        frame(0, 8'h10, 4'b0000, 0);
`else
        frame(1, 8'h21, 4'b0011, 0);
        frame(0, 8'h10, 4'b0011, 0);
        frame(1, 8'h21, 4'b0011, 0);
        frame(0, 8'h10, 4'b0000, 0);
`endif
        req_last = 4'b0000;

        // 6: tx_done already high at START must not end the frame
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h000000A5;
        tx_done   = 1'b1;
        #1;
        check("t6_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        step();
        check("t6_start", 32'(tx_start), 32'd1);
        step();
        step();
        step();
        check("t6_held_busy", 32'(busy), 32'd1);
        check("t6_held_cnt", 32'(sent_cnt), 32'd0);
        tx_done = 1'b0;
        step();
        check("t6_low_busy", 32'(busy), 32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("t6_edge_idle", 32'(busy), 32'd0);
        check("t6_edge_cnt", 32'(sent_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
